// File: rtl/lsu_mem_if.sv
// Word-wide req/gnt/rvalid data-memory port between the load/store unit (master)
// and data memory (slave).
interface lsu_mem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit: IDLE/REQ/WAIT/DONE FSM driving a word-wide memory port, with
// aligned and extended load writeback. Optional bus timeout under `LSU_TIMEOUT_EN.
module lsu_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic [4:0]            rd_in,
    lsu_mem_if.master             mem,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign_err,
    output logic                  bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e                state_q;
    size_e                 size_d, size_q;
    logic                  is_load_q, uns_q;
    logic [1:0]            lo_q;
    logic                  misalign_d;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d, rd_shift_d, load_data_d;

    logic                  ex_ready_q, mem_req_q, mem_we_q;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [3:0]            mem_be_q;
    logic                  wb_valid_q, wb_we_q, misalign_q, bus_err_q;
    logic [4:0]            wb_rd_q;

    // Loads treat 011/11x as W; stores treat anything above 010 as W.
    always_comb begin
        size_d = SZ_W;
        case (Funct3)
            3'b000:  size_d = SZ_B;
            3'b001:  size_d = SZ_H;
            3'b100:  if (MemRead) size_d = SZ_B;
            3'b101:  if (MemRead) size_d = SZ_H;
            default: size_d = SZ_W;
        endcase
    end

    assign misalign_d = ((size_d == SZ_H) && ALUResult[0]) ||
                        ((size_d == SZ_W) && (ALUResult[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = WrData;
        case (size_d)
            SZ_B: begin
                be_d    = 4'b0001 << ALUResult[1:0];
                wdata_d = {4{WrData[7:0]}};
            end
            SZ_H: begin
                be_d    = 4'b0011 << ALUResult[1:0];
                wdata_d = {2{WrData[15:0]}};
            end
            default: be_d = 4'b1111;
        endcase
        // Byte enables only mean something for writes.
        if (MemRead) be_d = 4'b0000;
    end

    assign rd_shift_d = mem.mem_rdata >> {lo_q, 3'b000};

    always_comb begin
        load_data_d = rd_shift_d;
        case (size_q)
            SZ_B:    load_data_d = {{(DATA_WIDTH-8){rd_shift_d[7] & ~uns_q}}, rd_shift_d[7:0]};
            SZ_H:    load_data_d = {{(DATA_WIDTH-16){rd_shift_d[15] & ~uns_q}}, rd_shift_d[15:0]};
            default: load_data_d = rd_shift_d;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            size_q      <= SZ_B;
            is_load_q   <= 1'b0;
            uns_q       <= 1'b0;
            lo_q        <= 2'b00;
            ex_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            // NOTE: wb_valid defaults low every cycle so DONE yields a one-cycle pulse.
            wb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && (MemRead || MemWrite)) begin
                        ex_ready_q  <= 1'b0;
                        is_load_q   <= MemRead;
                        size_q      <= size_d;
                        uns_q       <= Funct3[2];
                        lo_q        <= ALUResult[1:0];
                        wb_rd_q     <= rd_in;
                        mem_addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        mem_we_q    <= ~MemRead;
                        wb_we_q     <= 1'b0;
                        wb_data_q   <= '0;
                        bus_err_q   <= 1'b0;
                        if (misalign_d) begin
                            state_q    <= S_DONE;
                            wb_valid_q <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            mem_req_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (is_load_q) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q    <= S_DONE;
                            wb_valid_q <= 1'b1;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_q    <= S_DONE;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        bus_err_q  <= 1'b1;
                    end
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
`else
                    end
`endif
                end
                S_WAIT: begin
                    if (mem.mem_rvalid) begin
                        state_q    <= S_DONE;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b1;
                        wb_data_q  <= load_data_d;
`ifdef LSU_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_q    <= S_DONE;
                        wb_valid_q <= 1'b1;
                        bus_err_q  <= 1'b1;
                    end
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
`else
                    end
`endif
                end
                default: begin
                    state_q    <= S_IDLE;
                    ex_ready_q <= 1'b1;
                    wb_we_q    <= 1'b0;
                    wb_data_q  <= '0;
                    misalign_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready      = ex_ready_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_we         = wb_we_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misalign_err  = misalign_q;
    assign bus_err       = bus_err_q;
endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit: loads, stores, stalls, misalignment,
// reset abort and (with LSU_TIMEOUT_EN) the bus timeout.
module tb_lsu_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WrData;
    logic [4:0]  rd_in;
    logic        ex_ready, wb_valid, wb_we, misalign_err, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          checks = 0;
    int          errors = 0;

    lsu_mem_if #(.DATA_WIDTH(32)) mem_bus ();

    lsu_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WrData(WrData), .rd_in(rd_in), .mem(mem_bus),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single accept cycle; returns at the T+1 sample point.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdat, input logic [4:0] rdi);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
        ALUResult = addr; WrData = wdat; rd_in = rdi;
        tick();
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // Load with immediate gnt and rvalid; checks the extended result at T+3.
    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd3);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rdata;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check({tag, "_data"}, wb_data, exp);
        tick();
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b000; ALUResult = '0; WrData = '0; rd_in = '0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
        tick(); tick();
        check("rst_ex_ready", ex_ready, 1);
        check("rst_mem_req", mem_bus.mem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        reset = 1'b1;
        tick();

        // LB 0x1003: byte 0x80 sign-extended
        issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
        check("lb_req", mem_bus.mem_req, 1);
        check("lb_addr", mem_bus.mem_addr, 32'h0000_1000);
        check("lb_be", mem_bus.mem_be, 4'b0000);
        check("lb_we", mem_bus.mem_we, 0);
        check("lb_ex_ready_busy", ex_ready, 0);
        mem_bus.mem_gnt = 1'b1;
        tick();
        check("lb_req_drop_wait", mem_bus.mem_req, 0);
        check("lb_no_early_wb", wb_valid, 0);
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h80FF_1234;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check("lb_wb_valid_t3", wb_valid, 1);
        check("lb_wb_we", wb_we, 1);
        check("lb_wb_rd", wb_rd, 5'd7);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        tick();
        check("lb_wb_pulse_end", wb_valid, 0);
        check("lb_ex_ready_t4", ex_ready, 1);

        // rvalid while IDLE is ignored
        mem_bus.mem_rvalid = 1'b1;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check("idle_rvalid_no_wb", wb_valid, 0);
        check("idle_rvalid_ready", ex_ready, 1);

        // op with neither MemRead nor MemWrite is ignored
        issue(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1);
        check("nop_no_req", mem_bus.mem_req, 0);
        check("nop_ready", ex_ready, 1);

        // SH 0x2002
        issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0);
        check("sh_req", mem_bus.mem_req, 1);
        check("sh_we", mem_bus.mem_we, 1);
        check("sh_addr", mem_bus.mem_addr, 32'h0000_2000);
        check("sh_be", mem_bus.mem_be, 4'b1100);
        check("sh_wdata", mem_bus.mem_wdata, 32'hBEEF_BEEF);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        check("sh_wb_valid_t2", wb_valid, 1);
        check("sh_wb_we", wb_we, 0);
        check("sh_wb_data", wb_data, 0);
        tick();
        check("sh_ex_ready_t3", ex_ready, 1);

        // SB 0x3001 and SW-like store with Funct3 110
        issue(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 5'd0);
        check("sb_be", mem_bus.mem_be, 4'b0010);
        check("sb_wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
        mem_bus.mem_gnt = 1'b1; tick(); mem_bus.mem_gnt = 1'b0; tick();
        issue(1'b0, 1'b1, 3'b110, 32'h0000_3004, 32'hCAFE_F00D, 5'd0);
        check("sw_f3hi_be", mem_bus.mem_be, 4'b1111);
        check("sw_f3hi_wdata", mem_bus.mem_wdata, 32'hCAFE_F00D);
        mem_bus.mem_gnt = 1'b1; tick(); mem_bus.mem_gnt = 1'b0; tick();

        // LHU 0x0 with gnt stalled 5 cycles and a stray rvalid in REQ
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd9);
        for (int i = 0; i < 5; i++) begin
            check("lhu_stall_req", mem_bus.mem_req, 1);
            check("lhu_stall_addr", mem_bus.mem_addr, 32'h0);
            check("lhu_stall_be", mem_bus.mem_be, 4'b0000);
            check("lhu_stall_no_wb", wb_valid, 0);
            mem_bus.mem_rvalid = (i == 2);
            mem_bus.mem_rdata  = 32'hFFFF_FFFF;
            tick();
        end
        mem_bus.mem_rvalid = 1'b0;
        check("lhu_req_after_stall", mem_bus.mem_req, 1);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0000_8001;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check("lhu_wb_valid", wb_valid, 1);
        check("lhu_wb_data", wb_data, 32'h0000_8001);
        tick();

        // Extension variants
        quick_load("lh_a2", 3'b001, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001);
        quick_load("lbu_a1", 3'b100, 32'h0000_0001, 32'h0000_F000, 32'h0000_00F0);
        quick_load("lw_a0", 3'b010, 32'h0000_0010, 32'h89AB_CDEF, 32'h89AB_CDEF);
        quick_load("lw_f3_011", 3'b011, 32'h0000_0014, 32'h8000_0001, 32'h8000_0001);

        // LW 0x6 misaligned: no bus request, immediate error completion
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd4);
        check("mis_wb_valid_t1", wb_valid, 1);
        check("mis_err", misalign_err, 1);
        check("mis_wb_we", wb_we, 0);
        check("mis_no_req", mem_bus.mem_req, 0);
        tick();
        check("mis_err_clear", misalign_err, 0);
        check("mis_ready", ex_ready, 1);

        // LH at odd address is misaligned; LB at odd address is not
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 5'd4);
        check("mis_lh_err", misalign_err, 1);
        tick();

        // LW with gnt withheld for 16 cycles
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd5);
        for (int i = 0; i < 16; i++) begin
            check("tmo_req_held", mem_bus.mem_req, 1);
            check("tmo_no_wb", wb_valid, 0);
            tick();
        end
`ifdef LSU_TIMEOUT_EN
        check("tmo_wb_valid", wb_valid, 1);
        check("tmo_bus_err", bus_err, 1);
        check("tmo_wb_data", wb_data, 0);
        check("tmo_wb_we", wb_we, 0);
        check("tmo_req_drop", mem_bus.mem_req, 0);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1;
        check("tmo_ready", ex_ready, 1);
        check("tmo_pulse_end", wb_valid, 0);
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check("tmo_late_ignored", wb_valid, 0);
        check("tmo_late_no_req", mem_bus.mem_req, 0);
`else
        check("notmo_req_held", mem_bus.mem_req, 1);
        check("notmo_no_wb", wb_valid, 0);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check("notmo_wb_valid", wb_valid, 1);
        check("notmo_bus_err", bus_err, 0);
        check("notmo_wb_data", wb_data, 32'h0BAD_F00D);
`endif
        tick();

        // Reset during REQ drops mem_req without waiting for a clock edge
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6);
        check("rstreq_req_before", mem_bus.mem_req, 1);
        reset = 1'b0;
        #1;
        check("rstreq_req_async", mem_bus.mem_req, 0);
        check("rstreq_ready_async", ex_ready, 1);
        #1 reset = 1'b1;
        tick();

        // Reset during WAIT abandons the load; a later rvalid is ignored
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        check("rstwait_ready_before", ex_ready, 0);
        reset = 1'b0;
        #1;
        check("rstwait_req", mem_bus.mem_req, 0);
        check("rstwait_wb_valid", wb_valid, 0);
        check("rstwait_ready", ex_ready, 1);
        #1 reset = 1'b1;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check("rstwait_rvalid_ignored", wb_valid, 0);
        tick();
        check("rstwait_still_idle", wb_valid, 0);
        check("rstwait_ready_after", ex_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Load/store unit in the execute/memory boundary, directly downstream of the ALU. Consumes the ALU result as the effective address, gets its control from the decoder (MemRead, MemWrite, Funct3) and the store data from the register file. Drives a req/gnt/rvalid word-wide data-memory port. Returns an aligned, sign- or zero-extended load result, or a store-completion pulse, to writeback.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
TIMEOUT_CYCLES, 16, cycles allowed in REQ+WAIT before a bus error; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ex_valid  in  1  execute stage presents a memory op
ex_ready  out  1  unit can accept an op (high only in IDLE)
MemRead  in  1  op is a load
MemWrite  in  1  op is a store
Funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult  in  DATA_WIDTH  effective byte address
WrData  in  DATA_WIDTH  store data (rs2)
rd_in  in  5  destination register of the load
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  DATA_WIDTH  word address; bits [1:0] always 0
mem_be  out  4  byte enables
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read word
wb_valid  out  1  one-cycle completion pulse
wb_we  out  1  write wb_data to wb_rd (loads only)
wb_rd  out  5  destination register
wb_data  out  DATA_WIDTH  extended load result; 0 for stores and errors
misalign_err  out  1  qualifies wb_valid: access was misaligned
bus_err  out  1  qualifies wb_valid: timeout (0 without LSU_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0 except ex_ready=1. Any in-flight access is abandoned and mem_req drops immediately.
- FSM states: IDLE, REQ, WAIT, DONE. All memory-side and wb outputs are registered.
- IDLE: ex_ready=1. An op is accepted when ex_valid=1 and (MemRead or MemWrite) is high. On acceptance, latch address, Funct3, WrData, rd_in and the op type.
  - If MemRead and MemWrite are both high, the op is a load.
  - If the op is misaligned, next state is DONE: misalign_err=1, no mem_req. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Otherwise next state is REQ.
  - An op with ex_valid=1 but neither MemRead nor MemWrite is ignored.
- REQ: mem_req=1, mem_we=store. Address, be and wdata are held stable until mem_gnt.
  - On mem_gnt: a load goes to WAIT; a store goes to DONE.
  - mem_rvalid seen in REQ is ignored.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata and go to DONE.
- DONE: wb_valid=1 for exactly one cycle, then IDLE.
  - wb_we=1 only for a successful load.
  - misalign_err and bus_err are valid only in this cycle.
- Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
- Store data replication: B = {4{WrData[7:0]}}; H = {2{WrData[15:0]}}; W = WrData.
- Load extraction: shift mem_rdata right by 8*addr[1:0], then sign-extend for B/H and zero-extend for BU/HU. Funct3 011/11x on a load behaves as W. Store Funct3 above 010 behaves as SW.
- Best-case latency, accept at cycle T with gnt at T+1:
  - Load: rvalid at T+2, wb_valid at T+3, ex_ready again at T+4.
  - Store: wb_valid at T+2, ex_ready again at T+3.
  - Misaligned: wb_valid at T+1.
- mem_rvalid while in IDLE or DONE is ignored; no state change.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments every cycle in REQ or WAIT. On reaching TIMEOUT_CYCLES, the FSM goes to DONE with bus_err=1, wb_we=0 and wb_data=0. A late gnt or rvalid after the timeout is ignored.
- Undefined: there is no counter, the unit waits indefinitely, and bus_err is tied to 0.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, gnt and rvalid immediate → mem_addr 0x1000, mem_be 0000 (no write); wb_data 0xFFFF_FF80, wb_we=1, wb_valid at T+3.
- SH, addr 0x2002, WrData 0xDEAD_BEEF → mem_be 4'b1100, mem_wdata 0xBEEF_BEEF, mem_we=1; wb_valid at T+2 with wb_we=0.
- LHU, addr 0x0, gnt held low 5 cycles, rdata 0x0000_8001 → mem_req stays high with addr and be stable; wb_data 0x0000_8001 after gnt then rvalid.
- LW, addr 0x0006 → no mem_req; wb_valid at T+1 with misalign_err=1, wb_we=0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, LW with gnt never asserted → after 16 REQ cycles: wb_valid=1, bus_err=1, wb_data=0; a late gnt is ignored.
- Reset asserted while in WAIT → mem_req, wb_valid=0 and ex_ready=1 immediately; a following rvalid causes no wb_valid.
